// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Turns fare constants from BCD thumbwheels/keypad into binary for the
// fare accumulator. One result every BIN_W+2 cycles, start/busy/done handshake.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int R_W   = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [R_W-1:0]   r_work;   // {bcd part, bin part}
    logic [R_W-1:0]   r_next;   // r_work shifted right and nibble-corrected
    logic             bcd_bad;  // some incoming nibble is not a decimal digit

    // Flag any nibble of the incoming word above 9.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then take 3 off every BCD nibble >= 8.
    always_comb begin
        r_next = r_work >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_next[BIN_W + 4*i +: 4] >= 4'd8) begin
                r_next[BIN_W + 4*i +: 4] = r_next[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Control FSM, iteration counter and result/error registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            err     <= 1'b0;
            bin_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        cnt <= '0;
                        if (bcd_bad) begin
                            err     <= 1'b1;
                            bin_out <= '0;
                            state   <= S_DONE;
                        end else begin
                            state   <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        bin_out <= r_next[BIN_W-1:0];
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Working shift register: loaded on accept, stepped while shifting.
    always_ff @(posedge clk) begin
        // NOTE: datapath register carries no reset; it is always reloaded on accept before being used.
        if (state == S_IDLE && start) begin
            r_work <= {bcd_in, {BIN_W{1'b0}}};
        end else if (state == S_SHIFT) begin
            r_work <= r_next;
        end
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        busy = (state == S_SHIFT);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int BCD_W  = 4 * DIGITS;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [BCD_W-1:0] bcd_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [BIN_W-1:0] bin_out;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses and watch that done and busy never overlap.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) done_pulses++;
            total++;
            assert (!(done === 1'b1 && busy === 1'b1)) else begin
                bad++;
                $error("FAIL done_busy_overlap observed=1 expected=0");
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word with start high for one edge; scramble bcd_in afterwards.
    task automatic accept(input logic [BCD_W-1:0] v);
        bcd_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bcd_in = 16'hFFFF;
    endtask

    // Wait (bounded) for done; lat counts cycles after the accept edge.
    task automatic wait_done(input string tag, output int lat, output int bsy);
        lat = 1;
        bsy = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bsy++;
            tick();
            lat++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        if (done === 1'b1 && err === 1'b0)
            check({tag, "_bcd_residue"}, {16'd0, dut.r_work[BIN_W +: BCD_W]}, 32'd0);
    endtask

    initial begin
        int lat;
        int bsy;
        int p0;
        time t1;

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err",  {31'd0, err},  32'd0);
        check("rst_bin",  {18'd0, bin_out}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Zero input.
        accept(16'h0000);
        wait_done("zero", lat, bsy);
        check("zero_lat", lat, 32'd15);
        check("zero_bin", {18'd0, bin_out}, 32'd0);
        check("zero_err", {31'd0, err}, 32'd0);
        tick();

        // Largest value.
        accept(16'h9999);
        wait_done("max", lat, bsy);
        check("max_bin", {18'd0, bin_out}, 32'd9999);
        check("max_err", {31'd0, err}, 32'd0);
        check("max_busy_cycles", bsy, 32'd14);
        check("max_lat", lat, 32'd15);
        tick();

        // Back-to-back: 30 then 1234, second start in the first IDLE cycle.
        accept(16'h0030);
        wait_done("b2b_a", lat, bsy);
        check("b2b_a_bin", {18'd0, bin_out}, 32'd30);
        t1 = $time;
        tick();
        accept(16'h1234);
        check("b2b_hold_bin", {18'd0, bin_out}, 32'd30);
        wait_done("b2b_b", lat, bsy);
        check("b2b_b_bin", {18'd0, bin_out}, 32'd1234);
        check("b2b_spacing", ($time - t1) / 10, 32'd16);
        tick();

        // Invalid nibble, then a valid word clears err.
        accept(16'h12A4);
        wait_done("inv", lat, bsy);
        check("inv_lat", lat, 32'd1);
        check("inv_err", {31'd0, err}, 32'd1);
        check("inv_bin", {18'd0, bin_out}, 32'd0);
        tick();
        check("inv_err_held", {31'd0, err}, 32'd1);
        accept(16'h0005);
        check("inv_err_cleared", {31'd0, err}, 32'd0);
        wait_done("five", lat, bsy);
        check("five_bin", {18'd0, bin_out}, 32'd5);
        check("five_err", {31'd0, err}, 32'd0);
        tick();

        // Start while shifting is ignored.
        p0 = done_pulses;
        accept(16'h0500);
        repeat (4) tick();
        check("ign_busy", {31'd0, busy}, 32'd1);
        bcd_in = 16'h0001;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done("ign", lat, bsy);
        check("ign_bin", {18'd0, bin_out}, 32'd500);
        repeat (20) tick();
        check("ign_pulses", done_pulses - p0, 32'd1);
        check("ign_bin_held", {18'd0, bin_out}, 32'd500);

        // Reset in the middle of a conversion.
        p0 = done_pulses;
        accept(16'h4321);
        repeat (6) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_bin",  {18'd0, bin_out}, 32'd0);
        check("mid_rst_err",  {31'd0, err}, 32'd0);
        repeat (20) tick();
        check("mid_rst_pulses", done_pulses - p0, 32'd0);

        // Recovery after reset.
        accept(16'h4321);
        wait_done("recov", lat, bsy);
        check("recov_bin", {18'd0, bin_out}, 32'd4321);
        check("recov_lat", lat, 32'd15);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
